// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM state encoding and default bit timing.
// Optional even-parity bit enabled by defining UART_TX_PARITY_EN.
package uart_pkg;

  localparam int CLKS_PER_BIT_DFLT = 434;  // 50 MHz / 115200 baud

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and pulses o_tick on the last count.
// i_clr holds the count at zero so the first bit of a frame starts aligned.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DFLT,
  parameter int CNT_W        = 9
) (
  input  logic Clk,
  input  logic Rst,
  input  logic i_clr,
  output logic o_tick
);

  logic [CNT_W-1:0] r_cnt;

  assign o_tick = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_cnt <= '0;
    end else if (i_clr || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1 by default; 8E1 when UART_TX_PARITY_EN is defined.
// A rising edge on DatLock while idle launches one frame; requests during a frame are dropped.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DFLT,
  parameter int CNT_W        = 9
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       DatLock,
  input  logic [7:0] SendDat,
  output logic       Avl,
  output logic       Txd
);

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_shift, w_shift_nxt;
  logic [2:0]  r_idx,   w_idx_nxt;
  logic        r_prelock;
  logic        r_txd,   w_txd_nxt;
  logic        r_avl;
  logic        w_req;
  logic        w_tick;
  logic        w_clr;
`ifdef UART_TX_PARITY_EN
  logic        r_parity, w_parity_nxt;
`endif

  assign w_req = DatLock & ~r_prelock;
  assign w_clr = (r_state == IDLE);
  assign Avl   = r_avl;
  assign Txd   = r_txd;

  uart_baud_cnt #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_baud_cnt (
    .Clk    (Clk),
    .Rst    (Rst),
    .i_clr  (w_clr),
    .o_tick (w_tick)
  );

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt  = r_state;
    w_shift_nxt  = r_shift;
    w_idx_nxt    = r_idx;
`ifdef UART_TX_PARITY_EN
    w_parity_nxt = r_parity;
`endif
    unique case (r_state)
      IDLE: begin
        if (w_req) begin
          w_state_nxt  = START;
          w_shift_nxt  = SendDat;
          w_idx_nxt    = 3'd0;
`ifdef UART_TX_PARITY_EN
          w_parity_nxt = ^SendDat;
`endif
        end
      end
      START: if (w_tick) w_state_nxt = DATA;
      DATA: begin
        if (w_tick) begin
          w_shift_nxt = r_shift >> 1;
          w_idx_nxt   = r_idx + 3'd1;
          if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_state_nxt = PARITY;
`else
            w_state_nxt = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (w_tick) w_state_nxt = STOP;
`endif
      STOP: if (w_tick) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase

    // Line level is decoded from the next state so Txd changes on the same edge as the state.
    w_txd_nxt = 1'b1;
    unique case (w_state_nxt)
      START:   w_txd_nxt = 1'b0;
      DATA:    w_txd_nxt = w_shift_nxt[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  w_txd_nxt = w_parity_nxt;
`endif
      default: w_txd_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_idx     <= '0;
      r_prelock <= 1'b0;
      r_txd     <= 1'b1;
      r_avl     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_idx     <= w_idx_nxt;
      r_prelock <= DatLock;
      r_txd     <= w_txd_nxt;
      r_avl     <= (w_state_nxt == IDLE);
`ifdef UART_TX_PARITY_EN
      r_parity  <= w_parity_nxt;
`endif
    end
  end

endmodule
